multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several clocks, sharing one memory port between instruction and data accesses.
- Replaces the combinational single-cycle decoder path: decode is registered per instruction, and each control signal is asserted only in the state that needs it.
- Memory accesses use a req/ready handshake, so wait states are supported.

Parameters:
- RESET_STATE, 0, encoding of the FETCH state.
- TIMEOUT, 255, maximum cycles to wait for mem_ready before the controller raises fault.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr  in  32  instruction register contents (valid from DECODE onward)
- zero  in  1  ALU result == 0
- rs_neg  in  1  bit 31 of the rs register read value
- mem_ready  in  1  memory completed the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  request is a write (only with mem_req)
- iord  out  1  0: address = PC; 1: address = ALU output register
- irwrite  out  1  load IR from memory read data
- pcwrite  out  1  update PC
- pcsrc  out  2  00: PC+4, 01: branch target, 10: jump target
- regwrite  out  1  register file write enable
- destreg  out  5  destination register number
- memtoreg  out  1  writeback data from memory data register
- alusrcbimm  out  1  ALU operand B is the immediate
- alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 sltu, 101 lui (B<<16), 011 undefined
- retire  out  1  one-cycle pulse when an instruction completes
- fault  out  1  sticky; set on illegal opcode, illegal funct or memory timeout

Behaviour:
- Reset (reset==0, asynchronous): state=FETCH, timeout counter=0, fault=0. All outputs 0 except alucontrol=010.
- All outputs are Moore outputs, decoded from the state and the latched op/funct. Exception: dobranch-style conditional pcwrite in BRANCH uses zero/rs_neg combinationally.

States and transitions:
- FETCH: mem_req=1, iord=0, mem_we=0. On mem_ready: irwrite=1, pcwrite=1, pcsrc=00, then go to DECODE. Otherwise stay.
- DECODE: latch op=instr[31:26], funct=instr[5:0]. Next state:
  - 000000 with valid funct (100001, 100011, 100100, 100101, 101011) -> EXEC_R
  - 100011 or 101011 -> ADDR
  - 000100 or 000001 -> BRANCH
  - 001001, 001101, 001111 -> EXEC_I
  - 000010 -> JUMP
  - anything else -> HALT with fault=1
- EXEC_R: alusrcbimm=0; alucontrol from funct (100001->010, 100011->110, 100100->000, 100101->001, 101011->111). Next state WB_R.
- WB_R: regwrite=1, destreg=instr[15:11], memtoreg=0, retire=1. Next state FETCH.
- EXEC_I: alusrcbimm=1; addiu->010, ori->001, lui->101. Next state WB_I.
- WB_I: regwrite=1, destreg=instr[20:16], memtoreg=0, retire=1. Next state FETCH.
- ADDR: alusrcbimm=1, alucontrol=010. Next state MEM.
- MEM: mem_req=1, iord=1, mem_we=op[3]. On mem_ready: sw sets retire=1 and goes to FETCH; lw goes to WB_MEM.
- WB_MEM: regwrite=1, destreg=instr[20:16], memtoreg=1, retire=1. Next state FETCH.
- BRANCH: beq uses alucontrol=110, alusrcbimm=0, pcwrite=zero. bltz uses pcwrite=rs_neg. Both use pcsrc=01, retire=1. Next state FETCH.
- JUMP: pcwrite=1, pcsrc=10, retire=1. Next state FETCH.
- HALT: all enables 0, fault=1. Left only by reset.

Memory handshake and timeout:
- mem_req stays high and iord/mem_we stay stable until the cycle mem_ready is sampled high.
- mem_ready while mem_req=0 is ignored.
- An 8-bit counter increments each cycle that mem_req=1 && !mem_ready, and clears on mem_ready or on a state change.
- When the counter reaches TIMEOUT: go to HALT, fault=1.
- regwrite is never 1 outside WB_* states; pcwrite is never 1 outside FETCH, BRANCH and JUMP.
- Reset asserted mid-access: mem_req drops immediately (asynchronous), and no write enable fires afterwards.

Test Plan:
- addu $3,$1,$2 (0x00221821), mem_ready=1 on the first request cycle -> FETCH, DECODE, EXEC_R, WB_R. WB_R shows regwrite=1, destreg=3, alucontrol=010, retire=1. 4 cycles total.
- lw $5,8($4) (0x8C850008), instruction ready immediately, data ready after 3 wait cycles -> mem_req held 4 cycles in MEM with iord=1, mem_we=0. Then WB_MEM shows memtoreg=1, destreg=5. 8 cycles total.
- sw (0xAC850008) -> MEM shows mem_we=1. regwrite is never 1. retire pulses in the mem_ready cycle.
- beq with zero=1, then zero=0 -> BRANCH shows pcwrite=1, pcsrc=01 in the first case and pcwrite=0 in the second. bltz with rs_neg=1 -> pcwrite=1.
- Opcode 0x3F, or R-type funct 0x00 -> HALT, fault=1. mem_req stays 0 for 20 subsequent cycles. Asserting reset clears fault and returns to FETCH.
- mem_ready held 0 in FETCH -> fault=1 and HALT after 255 cycles. Separately, reset asserted mid-MEM drops mem_req asynchronously in the same cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared req/ready memory port, with a wait-state timeout and sticky fault.
module multicycle_controller #(
    parameter int unsigned RESET_STATE = 0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        rs_neg,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        irwrite,
    output logic        pcwrite,
    output logic [1:0]  pcsrc,
    output logic        regwrite,
    output logic [4:0]  destreg,
    output logic        memtoreg,
    output logic        alusrcbimm,
    output logic [2:0]  alucontrol,
    output logic        retire,
    output logic        fault
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_UNDF = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    // Timeout fires on the wait cycle whose count has reached TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Encodings are offsets from RESET_STATE so FETCH carries the reset encoding.
    typedef enum logic [3:0] {
        FETCH  = 4'(RESET_STATE),
        DECODE = 4'(RESET_STATE + 1),
        EXEC_R = 4'(RESET_STATE + 2),
        WB_R   = 4'(RESET_STATE + 3),
        EXEC_I = 4'(RESET_STATE + 4),
        WB_I   = 4'(RESET_STATE + 5),
        ADDR   = 4'(RESET_STATE + 6),
        MEM    = 4'(RESET_STATE + 7),
        WB_MEM = 4'(RESET_STATE + 8),
        BRANCH = 4'(RESET_STATE + 9),
        JUMP   = 4'(RESET_STATE + 10),
        HALT   = 4'(RESET_STATE + 11)
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic       wait_expired;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{instr[25:21], instr[10:6]};
    assign wait_expired      = (cnt_q == WAIT_LAST);

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLTU: funct_legal = 1'b1;
            default:                                  funct_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_r(input logic [5:0] f);
        case (f)
            FN_ADDU: alu_r = ALU_ADD;
            FN_SUBU: alu_r = ALU_SUB;
            FN_AND:  alu_r = ALU_AND;
            FN_OR:   alu_r = ALU_OR;
            FN_SLTU: alu_r = ALU_SLTU;
            default: alu_r = ALU_UNDF;
        endcase
    endfunction

    function automatic logic [2:0] alu_i(input logic [5:0] op);
        case (op)
            OP_ADDIU: alu_i = ALU_ADD;
            OP_ORI:   alu_i = ALU_OR;
            OP_LUI:   alu_i = ALU_LUI;
            default:  alu_i = ALU_UNDF;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            FETCH: begin
                if (mem_ready)         state_d = DECODE;
                else if (wait_expired) state_d = HALT;
            end
            DECODE: begin
                op_d    = instr[31:26];
                funct_d = instr[5:0];
                case (instr[31:26])
                    OP_RTYPE:                state_d = funct_legal(instr[5:0]) ? EXEC_R : HALT;
                    OP_LW, OP_SW:            state_d = ADDR;
                    OP_BEQ, OP_BLTZ:         state_d = BRANCH;
                    OP_ADDIU, OP_ORI, OP_LUI: state_d = EXEC_I;
                    OP_J:                    state_d = JUMP;
                    default:                 state_d = HALT;
                endcase
            end
            EXEC_R: state_d = WB_R;
            EXEC_I: state_d = WB_I;
            ADDR:   state_d = MEM;
            MEM: begin
                // op bit 3 separates sw (retires here) from lw (needs writeback)
                if (mem_ready)         state_d = op_q[3] ? FETCH : WB_MEM;
                else if (wait_expired) state_d = HALT;
            end
            WB_R, WB_I, WB_MEM, BRANCH, JUMP: state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        if (state_d == HALT) fault_d = 1'b1;

        if (mem_ready || (state_d != state_q)) cnt_d = '0;
        else if (mem_req)                      cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            funct_q <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Outputs are gated by reset itself so a request drops the moment reset asserts.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 2'b00;
        regwrite   = 1'b0;
        destreg    = '0;
        memtoreg   = 1'b0;
        alusrcbimm = 1'b0;
        alucontrol = ALU_ADD;
        retire     = 1'b0;
        fault      = 1'b0;
        if (reset) begin
            fault = fault_q;
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                EXEC_R: alucontrol = alu_r(funct_q);
                WB_R: begin
                    regwrite = 1'b1;
                    destreg  = instr[15:11];
                    retire   = 1'b1;
                end
                EXEC_I: begin
                    alusrcbimm = 1'b1;
                    alucontrol = alu_i(op_q);
                end
                WB_I: begin
                    regwrite = 1'b1;
                    destreg  = instr[20:16];
                    retire   = 1'b1;
                end
                ADDR: alusrcbimm = 1'b1;
                MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = op_q[3];
                    retire  = op_q[3] & mem_ready;
                end
                WB_MEM: begin
                    regwrite = 1'b1;
                    destreg  = instr[20:16];
                    memtoreg = 1'b1;
                    retire   = 1'b1;
                end
                BRANCH: begin
                    pcsrc  = 2'b01;
                    retire = 1'b1;
                    if (op_q == OP_BEQ) begin
                        alucontrol = ALU_SUB;
                        pcwrite    = zero;
                    end else begin
                        pcwrite = rs_neg;
                    end
                end
                JUMP: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                    retire  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds an expected per-cycle output trace from
// instruction-level rules and plays it against the DUT with random wait states.
module tb_multicycle_controller;

    localparam int TO = 255;

    typedef struct packed {
        logic       fault;
        logic       retire;
        logic [2:0] alu;
        logic       bimm;
        logic       m2r;
        logic [4:0] dest;
        logic       rw;
        logic [1:0] pcsrc;
        logic       pcw;
        logic       irw;
        logic       iord;
        logic       we;
        logic       req;
    } outs_t;

    typedef struct {
        outs_t       exp;
        logic        rdy;
        logic        z;
        logic        n;
        logic [31:0] ins;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero, rs_neg, mem_ready;
    logic        mem_req, mem_we, iord, irwrite, pcwrite, regwrite, memtoreg, alusrcbimm, retire, fault;
    logic [1:0]  pcsrc;
    logic [4:0]  destreg;
    logic [2:0]  alucontrol;
    outs_t       act;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    cyc_t plan[$];

    multicycle_controller #(.RESET_STATE(0), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .rs_neg(rs_neg),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .regwrite(regwrite),
        .destreg(destreg), .memtoreg(memtoreg), .alusrcbimm(alusrcbimm),
        .alucontrol(alucontrol), .retire(retire), .fault(fault)
    );

    always #5 clk = ~clk;

    assign act = {fault, retire, alucontrol, alusrcbimm, memtoreg, destreg, regwrite,
                  pcsrc, pcwrite, irwrite, iord, mem_we, mem_req};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic outs_t idle();
        outs_t o = '0;
        o.alu = 3'b010;
        return o;
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            6'h21:   return 4'b1010;
            6'h23:   return 4'b1110;
            6'h24:   return 4'b1000;
            6'h25:   return 4'b1001;
            6'h2B:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        case (op)
            6'h00, 6'h23, 6'h2B, 6'h04, 6'h01, 6'h09, 6'h0D, 6'h0F, 6'h02: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input outs_t o, input logic rdy, input logic z, input logic n, input logic [31:0] ins);
        cyc_t c;
        c.exp = o; c.rdy = rdy; c.z = z; c.n = n; c.ins = ins;
        plan.push_back(c);
    endtask

    task automatic push_r(input outs_t o, input logic [31:0] ins);
        push(o, 1'($urandom), 1'($urandom), 1'($urandom), ins);
    endtask

    task automatic plan_halt(input int cycles, input logic [31:0] ins);
        outs_t o = idle();
        o.fault = 1'b1;
        for (int k = 0; k < cycles; k++) push_r(o, ins);
    endtask

    // Expected trace for one instruction; fw/mw are wait cycles before mem_ready (>=TO never answers).
    task automatic plan_instr(input logic [31:0] ins, input int fw, input int mw,
                              input logic zb, input logic nb, output bit halted);
        outs_t o;
        logic [5:0] op;
        logic [3:0] ra;
        logic [31:0] prev;
        halted = 1'b0;
        op = ins[31:26];
        prev = $urandom();
        for (int k = 0; k < ((fw >= TO) ? TO : fw + 1); k++) begin
            o = idle();
            o.req = 1'b1;
            o.irw = (k == fw);
            o.pcw = (k == fw);
            push(o, (k == fw), 1'($urandom), 1'($urandom), prev);
        end
        if (fw >= TO) begin
            plan_halt(20, prev);
            halted = 1'b1;
            return;
        end
        push_r(idle(), ins);
        ra = r_alu(ins[5:0]);
        if (!op_known(op) || (op == 6'h00 && !ra[3])) begin
            plan_halt(20, ins);
            halted = 1'b1;
            return;
        end
        o = idle();
        case (op)
            6'h00: begin
                o.alu = ra[2:0];
                push_r(o, ins);
                o = idle(); o.rw = 1'b1; o.dest = ins[15:11]; o.retire = 1'b1;
                push_r(o, ins);
            end
            6'h09, 6'h0D, 6'h0F: begin
                o.bimm = 1'b1;
                o.alu  = (op == 6'h09) ? 3'b010 : (op == 6'h0D) ? 3'b001 : 3'b101;
                push_r(o, ins);
                o = idle(); o.rw = 1'b1; o.dest = ins[20:16]; o.retire = 1'b1;
                push_r(o, ins);
            end
            6'h23, 6'h2B: begin
                o.bimm = 1'b1;
                push_r(o, ins);
                for (int k = 0; k < ((mw >= TO) ? TO : mw + 1); k++) begin
                    o = idle();
                    o.req = 1'b1; o.iord = 1'b1; o.we = (op == 6'h2B);
                    o.retire = (op == 6'h2B) && (k == mw);
                    push(o, (k == mw), 1'($urandom), 1'($urandom), ins);
                end
                if (mw >= TO) begin
                    plan_halt(20, ins);
                    halted = 1'b1;
                end else if (op == 6'h23) begin
                    o = idle(); o.rw = 1'b1; o.dest = ins[20:16]; o.m2r = 1'b1; o.retire = 1'b1;
                    push_r(o, ins);
                end
            end
            6'h04: begin
                o.alu = 3'b110; o.pcw = zb; o.pcsrc = 2'b01; o.retire = 1'b1;
                push(o, 1'($urandom), zb, nb, ins);
            end
            6'h01: begin
                o.pcw = nb; o.pcsrc = 2'b01; o.retire = 1'b1;
                push(o, 1'($urandom), zb, nb, ins);
            end
            default: begin
                o.pcw = 1'b1; o.pcsrc = 2'b10; o.retire = 1'b1;
                push_r(o, ins);
            end
        endcase
    endtask

    // Called at posedge+1; leaves the bench at posedge+1.
    task automatic run_plan(input int limit);
        int done = 0;
        cyc_t c;
        while (plan.size() > 0 && (limit < 0 || done < limit)) begin
            c = plan.pop_front();
            mem_ready = c.rdy; zero = c.z; rs_neg = c.n; instr = c.ins;
            @(negedge clk);
            check($sformatf("outs c%0d i%h", cyc, c.ins), 32'(act), 32'(c.exp));
            @(posedge clk);
            #1;
            cyc++;
            done++;
        end
    endtask

    task automatic do_reset(input string tag);
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        check(tag, 32'(act), 32'(idle()));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic exec(input logic [31:0] ins, input int fw, input int mw, input logic zb, input logic nb);
        bit h;
        plan_instr(ins, fw, mw, zb, nb, h);
        run_plan(-1);
        if (h) do_reset("reset_after_halt");
    endtask

    function automatic logic [31:0] rand_instr(input int cls);
        logic [31:0] i;
        logic [5:0]  f;
        logic [3:0]  ra;
        logic [5:0]  ops[3];
        logic [5:0]  fns[5];
        ops = '{6'h09, 6'h0D, 6'h0F};
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2B};
        i = $urandom();
        case (cls)
            0, 9: begin i[31:26] = 6'h00; i[5:0] = fns[$urandom_range(0, 4)]; end
            1: begin
                i[31:26] = 6'h00;
                for (int t = 0; t < 64; t++) begin
                    f = 6'($urandom());
                    ra = r_alu(f);
                    if (!ra[3]) break;
                end
                if (ra[3]) f = 6'h00;
                i[5:0] = f;
            end
            2: i[31:26] = 6'h23;
            3: i[31:26] = 6'h2B;
            4: i[31:26] = 6'h04;
            5: i[31:26] = 6'h01;
            6: i[31:26] = ops[$urandom_range(0, 2)];
            7: i[31:26] = 6'h02;
            default: begin
                for (int t = 0; t < 64; t++) begin
                    f = 6'($urandom());
                    if (!op_known(f)) break;
                end
                if (op_known(f)) f = 6'h3F;
                i[31:26] = f;
            end
        endcase
        return i;
    endfunction

    initial begin
        bit h;
        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; rs_neg = 1'b0; instr = '0;
        #1;
        check("reset_state", 32'(act), 32'(idle()));
        @(posedge clk);
        #1;
        reset = 1'b1;

        exec(32'h00221821, 0, 0, 1'b0, 1'b0);   // addu $3,$1,$2
        exec(32'h8C850008, 0, 3, 1'b0, 1'b0);   // lw $5,8($4)
        exec(32'hAC850008, 1, 2, 1'b0, 1'b0);   // sw
        exec(32'h10220004, 0, 0, 1'b1, 1'b0);   // beq taken
        exec(32'h10220004, 2, 0, 1'b0, 1'b1);   // beq not taken
        exec(32'h04200003, 0, 0, 1'b0, 1'b1);   // bltz taken
        exec(32'h04200003, 0, 0, 1'b1, 1'b0);   // bltz not taken
        exec(32'h24220005, 0, 0, 1'b0, 1'b0);   // addiu
        exec(32'h34220005, 1, 0, 1'b0, 1'b0);   // ori
        exec(32'h3C020005, 0, 0, 1'b0, 1'b0);   // lui
        exec(32'h08000010, 0, 0, 1'b0, 1'b0);   // j
        exec(32'hFC000000, 0, 0, 1'b0, 1'b0);   // illegal opcode
        exec(32'h00221800, 0, 0, 1'b0, 1'b0);   // illegal funct
        exec(32'h00221821, TO, 0, 1'b0, 1'b0);  // fetch timeout
        exec(32'h8C850008, 0, TO, 1'b0, 1'b0);  // data timeout

        // Reset in the middle of a data access.
        plan_instr(32'h8C850008, 0, 10, 1'b0, 1'b0, h);
        run_plan(6);
        plan.delete();
        mem_ready = 1'b0;
        #1;
        check("midmem_req_before", 32'(mem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("midmem_reset", 32'(act), 32'(idle()));
        @(posedge clk);
        #1;
        reset = 1'b1;
        exec(32'h00221821, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            exec(rand_instr($urandom_range(0, 9)), $urandom_range(0, 3), $urandom_range(0, 4),
                 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
